// File: rtl/digit_pkg.sv
// Shared sizing constants and FSM encoding for the digit classifier sequencer.
package digit_pkg;

    localparam int N_CLASSES = 10;
    localparam int CHUNKS    = 4;
    localparam int ACC_W     = 22;
    localparam int CLS_W     = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/argmax_track.sv
// Signed running maximum with index; a tie keeps the earlier (lower) index.
module argmax_track
    import digit_pkg::*;
#(
    parameter int VAL_W = ACC_W,
    parameter int IDX_W = CLS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic             load,
    input  logic [VAL_W-1:0] value,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] win_idx
);

    logic signed [VAL_W-1:0] max_val;
    logic [IDX_W-1:0]        max_idx;
    logic                    take;

    // win_idx already includes the candidate presented this cycle, so the
    // final class can be resolved on the same edge it is captured.
    assign take    = valid && (load || ($signed(value) > max_val));
    assign win_idx = take ? idx : max_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (clear) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (take) begin
            max_val <= $signed(value);
            max_idx <= idx;
        end
    end

endmodule

// File: rtl/digit_classifier_ctrl.sv
// Sequencer for the mac3_acc neuron datapath: walks the ROMs per class,
// frames the accumulator, captures class scores and reports the argmax digit.
module digit_classifier_ctrl
    import digit_pkg::*;
#(
    parameter int N_CLASSES = digit_pkg::N_CLASSES,
    parameter int CHUNKS    = digit_pkg::CHUNKS,
    parameter int ACC_W     = digit_pkg::ACC_W,
    parameter int ADDR_W    = 6,
    parameter int MAC_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        bias_sel,
    output logic              mac_en,
    output logic              mac_first,
    input  logic [ACC_W-1:0]  acc_in,
    output logic              score_valid,
    output logic [3:0]        score_idx,
    output logic [ACC_W-1:0]  class_score,
    output logic              done,
    output logic [3:0]        class_id
);

    localparam int LAST_ADDR = N_CLASSES * CHUNKS - 1;
    localparam int CHUNK_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    logic [1:0]         state;
    logic [CHUNK_W-1:0] chunk_cnt;
    logic [CLS_W-1:0]   cls_cnt;
    logic               accept;
    logic               feed;
    logic               feed_last_chunk;
    logic               feed_last_addr;
    logic [MAC_LAT-1:0] last_pipe;
    logic [CLS_W-1:0]   idx_pipe [MAC_LAT];
    logic               capture;
    logic               final_capture;
    logic [CLS_W-1:0]   cap_idx;
    logic [CLS_W-1:0]   win_idx;

    assign accept          = (state == ST_IDLE) && start;
    assign feed            = (state == ST_FEED);
    assign feed_last_chunk = feed && (chunk_cnt == CHUNK_W'(CHUNKS - 1));
    assign feed_last_addr  = feed && (mem_addr == ADDR_W'(LAST_ADDR));
    assign capture         = last_pipe[MAC_LAT-1];
    assign cap_idx         = idx_pipe[MAC_LAT-1];
    assign final_capture   = capture && (cap_idx == CLS_W'(N_CLASSES - 1));
    assign busy            = (state != ST_IDLE) || done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_addr  <= '0;
            chunk_cnt <= '0;
            cls_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_FEED;
                        mem_addr  <= '0;
                        chunk_cnt <= '0;
                        cls_cnt   <= '0;
                    end
                end
                ST_FEED: begin
                    if (feed_last_addr) begin
                        state <= ST_DRAIN;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        if (chunk_cnt == CHUNK_W'(CHUNKS - 1)) begin
                            chunk_cnt <= '0;
                            cls_cnt   <= cls_cnt + CLS_W'(1);
                        end else begin
                            chunk_cnt <= chunk_cnt + CHUNK_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (final_capture) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Address-phase flags delayed one cycle to line up with ROM read data;
    // the last-chunk flag then rides a MAC_LAT delay line to the capture point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_en    <= 1'b0;
            mac_first <= 1'b0;
            bias_sel  <= '0;
            last_pipe <= '0;
            for (int i = 0; i < MAC_LAT; i++) idx_pipe[i] <= '0;
        end else begin
            mac_en       <= feed;
            mac_first    <= feed && (chunk_cnt == '0);
            if (feed) bias_sel <= cls_cnt;
            last_pipe[0] <= feed_last_chunk;
            idx_pipe[0]  <= cls_cnt;
            for (int i = 1; i < MAC_LAT; i++) begin
                last_pipe[i] <= last_pipe[i-1];
                idx_pipe[i]  <= idx_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_valid <= 1'b0;
            score_idx   <= '0;
            class_score <= '0;
            done        <= 1'b0;
            class_id    <= '0;
        end else begin
            score_valid <= capture;
            if (capture) begin
                class_score <= acc_in;
                score_idx   <= cap_idx;
            end
            done <= final_capture;
            if (final_capture) class_id <= win_idx;
        end
    end

    argmax_track #(
        .VAL_W (ACC_W),
        .IDX_W (CLS_W)
    ) u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .valid   (capture),
        .load    (cap_idx == '0),
        .value   (acc_in),
        .idx     (cap_idx),
        .win_idx (win_idx)
    );

endmodule

// File: tb/tb_digit_classifier_ctrl.sv
// Directed and randomized checks of the classifier sequencer against a stub
// 1-cycle ROM plus accumulator and an argmax reference computed from scores.
module tb_digit_classifier_ctrl;

    localparam int NC = 10;
    localparam int CH = 4;
    localparam int LAST_ADDR = NC * CH - 1;
    localparam int DONE_N = CH * NC + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic [5:0]  mem_addr;
    logic [3:0]  bias_sel;
    logic        mac_en;
    logic        mac_first;
    logic [21:0] acc_in;
    logic        score_valid;
    logic [3:0]  score_idx;
    logic [21:0] class_score;
    logic        done;
    logic [3:0]  class_id;

    logic signed [21:0] rom [64];
    logic signed [21:0] rom_q;
    logic signed [21:0] acc;

    int total = 0;
    int bad = 0;
    int sc [NC];
    int ref_score [NC];
    int ref_class = 0;
    int prev_class_id = 0;

    always #5 clk = ~clk;

    digit_classifier_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .bias_sel    (bias_sel),
        .mac_en      (mac_en),
        .mac_first   (mac_first),
        .acc_in      (acc_in),
        .score_valid (score_valid),
        .score_idx   (score_idx),
        .class_score (class_score),
        .done        (done),
        .class_id    (class_id)
    );

    // Stand-in for the ROMs and mac3_acc: registered read, load on first chunk.
    always @(posedge clk) begin
        rom_q <= rom[mem_addr];
        if (mac_en) acc <= mac_first ? rom_q : acc + rom_q;
    end
    assign acc_in = acc;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Splits each class score over the chunks randomly and derives the argmax.
    task automatic loadImage(input int s [NC]);
        for (int a = 0; a < 64; a++) rom[a] = '0;
        for (int k = 0; k < NC; k++) begin
            int rest = 0;
            for (int c = 1; c < CH; c++) begin
                int v = int'($urandom_range(4000)) - 2000;
                rom[k*CH + c] = 22'(v);
                rest += v;
            end
            rom[k*CH] = 22'(s[k] - rest);
            ref_score[k] = s[k];
        end
        ref_class = 0;
        for (int k = 1; k < NC; k++)
            if (s[k] > s[ref_class]) ref_class = k;
    endtask

    task automatic checkAllZero(input string pre);
        checkOutput({pre, "_busy"}, 32'(busy), 32'(0));
        checkOutput({pre, "_addr"}, 32'(mem_addr), 32'(0));
        checkOutput({pre, "_bias"}, 32'(bias_sel), 32'(0));
        checkOutput({pre, "_en"}, 32'(mac_en), 32'(0));
        checkOutput({pre, "_first"}, 32'(mac_first), 32'(0));
        checkOutput({pre, "_sv"}, 32'(score_valid), 32'(0));
        checkOutput({pre, "_sidx"}, 32'(score_idx), 32'(0));
        checkOutput({pre, "_score"}, 32'(class_score), 32'(0));
        checkOutput({pre, "_done"}, 32'(done), 32'(0));
        checkOutput({pre, "_cid"}, 32'(class_id), 32'(0));
    endtask

    task automatic idleCheck(input int cycles, input int exp_addr);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            checkOutput("idle_busy", 32'(busy), 32'(0));
            checkOutput("idle_en", 32'(mac_en), 32'(0));
            checkOutput("idle_done", 32'(done), 32'(0));
            checkOutput("idle_sv", 32'(score_valid), 32'(0));
            checkOutput("idle_addr", 32'(mem_addr), 32'(exp_addr));
        end
    endtask

    // One image from E0; keep_until holds start high, glitch_at pulses it
    // mid-run, abort_at pulls reset low in that cycle (negative = unused).
    task automatic applyStimulus(input int keep_until, input int glitch_at, input int abort_at);
        start = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n <= DONE_N; n++) begin
            bit exp_en, exp_first, exp_sv;
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (n == abort_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                checkAllZero("abort");
                @(posedge clk); #1;
                rst_n = 1'b1;
                prev_class_id = 0;
                idleCheck(4, 0);
                return;
            end
            exp_en    = (n >= 1) && (n <= LAST_ADDR + 1);
            exp_first = exp_en && ((n - 1) % CH == 0);
            exp_sv    = (n >= CH + 2) && ((n - CH - 2) % CH == 0);
            checkOutput("busy", 32'(busy), 32'(1));
            checkOutput("mem_addr", 32'(mem_addr), 32'((n <= LAST_ADDR) ? n : LAST_ADDR));
            checkOutput("mac_en", 32'(mac_en), 32'(exp_en));
            checkOutput("mac_first", 32'(mac_first), 32'(exp_first));
            if (exp_en) checkOutput("bias_sel", 32'(bias_sel), 32'((n - 1) / CH));
            checkOutput("score_valid", 32'(score_valid), 32'(exp_sv));
            if (exp_sv) begin
                int k = (n - CH - 2) / CH;
                logic [21:0] es = ref_score[k][21:0];
                checkOutput("score_idx", 32'(score_idx), 32'(k));
                checkOutput("class_score", 32'(class_score), 32'(es));
            end
            checkOutput("done", 32'(done), 32'(n == DONE_N));
            if (n == 0) checkOutput("class_id_hold", 32'(class_id), 32'(prev_class_id));
            if (n == DONE_N) checkOutput("class_id", 32'(class_id), 32'(ref_class));
            start = (n < keep_until) || (n == glitch_at);
        end
        prev_class_id = ref_class;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        acc   = '0;
        for (int a = 0; a < 64; a++) rom[a] = '0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        idleCheck(2, 0);

        $display("[TB] argmax with ties");
        sc = '{5, -3, 100, 7, 100, 0, -50, 99, 1, 2};
        loadImage(sc);
        applyStimulus(0, -1, -1);
        idleCheck(3, LAST_ADDR);

        $display("[TB] all-negative scores");
        sc = '{-10, -2, -7, -15, -20, -30, -4, -8, -12, -9};
        loadImage(sc);
        applyStimulus(0, -1, -1);

        $display("[TB] start held high");
        for (int k = 0; k < NC; k++) sc[k] = int'($urandom_range(200000)) - 100000;
        loadImage(sc);
        applyStimulus(100, -1, -1);
        applyStimulus(17, -1, -1);
        idleCheck(3, LAST_ADDR);

        $display("[TB] start pulse while busy");
        for (int k = 0; k < NC; k++) sc[k] = int'($urandom_range(3));
        loadImage(sc);
        applyStimulus(0, 20, -1);

        $display("[TB] reset mid-feed");
        for (int k = 0; k < NC; k++) sc[k] = int'($urandom_range(200000)) - 100000;
        loadImage(sc);
        applyStimulus(0, -1, 15);
        applyStimulus(0, -1, -1);

        $display("[TB] random images");
        for (int img = 0; img < 4; img++) begin
            for (int k = 0; k < NC; k++) sc[k] = int'($urandom_range(1000000)) - 500000;
            loadImage(sc);
            applyStimulus(0, -1, -1);
            idleCheck(1, LAST_ADDR);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
